// File: rtl/ddr3_rx_pkg.sv
// Shared constants, burst mode type and Gray-code helpers for the DDR3 read capture path.
// No logic, so no latency or backpressure of its own.
package ddr3_rx_pkg;

    localparam int BEATS_BL8 = 8;
    localparam int BEATS_BC4 = 4;

    typedef enum logic {
        MODE_BL8 = 1'b0,
        MODE_BC4 = 1'b1
    } mode_e;

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ddr3_rx_burst_buffer_if.sv
// Byte-lane read capture bus: PHY-side listen/strobe/DQ inputs and the drain valid/ready port.
// Pure wiring; the drain side stalls on rd_ready low with rd_data/rd_last held.
interface ddr3_rx_burst_buffer_if #(
    parameter int DW = 16
) ();
    logic          listen;
    logic          bc4;
    logic          strobe;
    logic [DW-1:0] din;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          overflow;

    modport master (
        output listen, bc4, strobe, din, rd_ready,
        input  rd_valid, rd_data, rd_last, overflow
    );

    modport slave (
        input  listen, bc4, strobe, din, rd_ready,
        output rd_valid, rd_data, rd_last, overflow
    );
endinterface

// File: rtl/ddr3_strobe_filter.sv
// DQS delay line and gate, per-burst edge counter and Gray write pointer in the strobe domain.
// Pointer advances on the final falling edge; no backpressure (admission is controlled upstream).
module ddr3_strobe_filter
    import ddr3_rx_pkg::*;
#(
    parameter int SLOTS      = 4,
    parameter int DLY_STAGES = 5,
    localparam int AW        = $clog2(SLOTS),
    localparam int PW        = AW + 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          strobe_i,
    input  logic          listen_acc_i,
    input  logic          bc4_i,
    output logic          fstrobe_o,
    output logic          fstrobe_n_o,
    output logic [1:0]    edge_cnt_o,
    output logic [AW-1:0] wr_slot_o,
    output logic [PW-1:0] wr_gray_o
);

    (* dont_touch = "true" *) logic [DLY_STAGES:0] dly;

    assign dly[0] = strobe_i;
    for (genvar g = 0; g < DLY_STAGES; g++) begin : g_dly
        assign dly[g+1] = dly[g];
    end

    // F0 is set from clk and cleared from the strobe domain; two toggles keep each flop single-clocked.
    logic  set_tog_q, clr_tog_q, clr_tog_d;
    mode_e mode_q;
    logic  f0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            set_tog_q <= 1'b0;
            mode_q    <= MODE_BL8;
        end else if (listen_acc_i) begin
            set_tog_q <= ~set_tog_q;
            mode_q    <= bc4_i ? MODE_BC4 : MODE_BL8;
        end
    end

    assign f0          = set_tog_q ^ clr_tog_q;
    assign fstrobe_o   = dly[DLY_STAGES] & (listen_acc_i | f0);
    assign fstrobe_n_o = ~fstrobe_o;

    logic [1:0]    edge_cnt_q, edge_cnt_d, last_edge;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_gray_q;
    logic          final_edge;

    assign last_edge  = (mode_q == MODE_BC4) ? 2'(BEATS_BC4 / 2 - 1) : 2'(BEATS_BL8 / 2 - 1);
    assign final_edge = (edge_cnt_q == last_edge);

    always_comb begin
        edge_cnt_d = edge_cnt_q + 2'd1;
        wr_ptr_d   = wr_ptr_q;
        clr_tog_d  = clr_tog_q;
        if (final_edge) begin
            edge_cnt_d = 2'd0;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            clr_tog_d  = ~clr_tog_q;
        end
    end

    always_ff @(posedge fstrobe_n_o or posedge reset_i) begin
        if (reset_i) begin
            edge_cnt_q <= 2'd0;
            wr_ptr_q   <= '0;
            wr_gray_q  <= '0;
            clr_tog_q  <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_gray_q  <= PW'(bin2gray(8'(wr_ptr_d)));
            clr_tog_q  <= clr_tog_d;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
    assign wr_slot_o  = wr_ptr_q[AW-1:0];
    assign wr_gray_o  = wr_gray_q;

endmodule

// File: rtl/ddr3_rx_burst_buffer.sv
// DDR3 byte-lane read capture ring: DQ captured on both DQS edges, drained beat by beat in clk.
// rd_valid 2 clk after burst end; 1 beat/clk; rd_ready low holds the beat; listen dropped when full.
module ddr3_rx_burst_buffer
    import ddr3_rx_pkg::*;
#(
    parameter int DW         = 16,
    parameter int SLOTS      = 4,
    parameter int DLY_STAGES = 5,
    localparam int AW        = $clog2(SLOTS),
    localparam int PW        = AW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    ddr3_rx_burst_buffer_if.slave  rx
);

    logic [PW-1:0] issued_q, rd_ptr_q, outstanding, wr_gray, sync1_q, sync2_q, wr_ptr_sync;
    logic [AW-1:0] wr_slot, rd_slot;
    logic [1:0]    edge_cnt;
    logic [2:0]    rd_beat_q, last_beat;
    logic          listen_acc, slots_full, fstrobe, fstrobe_n, overflow_q, pop;
    mode_e         mode_q [SLOTS];

    assign outstanding = issued_q - rd_ptr_q;
    assign slots_full  = (outstanding == PW'(SLOTS));
    assign listen_acc  = rx.listen & ~slots_full;

    ddr3_strobe_filter #(
        .SLOTS      (SLOTS),
        .DLY_STAGES (DLY_STAGES)
    ) u_filter (
        .clk_i        (clk),
        .reset_i      (reset),
        .strobe_i     (rx.strobe),
        .listen_acc_i (listen_acc),
        .bc4_i        (rx.bc4),
        .fstrobe_o    (fstrobe),
        .fstrobe_n_o  (fstrobe_n),
        .edge_cnt_o   (edge_cnt),
        .wr_slot_o    (wr_slot),
        .wr_gray_o    (wr_gray)
    );

    // Even beats land on rising edges, odd beats on falling edges; one array per edge keeps a single writer each.
    logic [DW-1:0] mem_even_q [SLOTS][4];
    logic [DW-1:0] mem_odd_q  [SLOTS][4];

    always_ff @(posedge fstrobe or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++)
                for (int b = 0; b < 4; b++)
                    mem_even_q[s][b] <= '0;
        end else begin
            mem_even_q[wr_slot][edge_cnt] <= rx.din;
        end
    end

    always_ff @(posedge fstrobe_n or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SLOTS; s++)
                for (int b = 0; b < 4; b++)
                    mem_odd_q[s][b] <= '0;
        end else begin
            mem_odd_q[wr_slot][edge_cnt] <= rx.din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= wr_gray;
            sync2_q <= sync1_q;
        end
    end

    assign wr_ptr_sync = PW'(gray2bin(8'(sync2_q)));

    assign rd_slot     = rd_ptr_q[AW-1:0];
    assign last_beat   = (mode_q[rd_slot] == MODE_BC4) ? 3'(BEATS_BC4 - 1) : 3'(BEATS_BL8 - 1);
    assign rx.rd_valid = (wr_ptr_sync != rd_ptr_q);
    assign rx.rd_last  = (rd_beat_q == last_beat);
    assign rx.rd_data  = rd_beat_q[0] ? mem_odd_q[rd_slot][rd_beat_q[2:1]]
                                      : mem_even_q[rd_slot][rd_beat_q[2:1]];
    assign rx.overflow = overflow_q;
    assign pop         = rx.rd_valid & rx.rd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q   <= '0;
            overflow_q <= 1'b0;
            for (int s = 0; s < SLOTS; s++) mode_q[s] <= MODE_BL8;
        end else begin
            if (listen_acc) begin
                issued_q                 <= issued_q + PW'(1);
                mode_q[issued_q[AW-1:0]] <= rx.bc4 ? MODE_BC4 : MODE_BL8;
            end
            if (rx.listen & slots_full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            rd_beat_q <= 3'd0;
        end else if (pop) begin
            if (rx.rd_last) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                rd_beat_q <= 3'd0;
            end else begin
                rd_beat_q <= rd_beat_q + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_rx_burst_buffer.sv
// Scoreboard bench for ddr3_rx_burst_buffer: bursts are queued as expected beats when issued,
// a negedge monitor pops and compares every accepted beat and checks holds under stall.
module tb_ddr3_rx_burst_buffer;
    localparam int DW    = 16;
    localparam int SLOTS = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ddr3_rx_burst_buffer_if #(.DW(DW)) rx ();

    ddr3_rx_burst_buffer #(.DW(DW), .SLOTS(SLOTS), .DLY_STAGES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx)
    );

    int tests = 0;
    int fails = 0;
    logic [DW:0] exp_q[$];
    int n_acc = 0;
    int n_done = 0;
    int ready_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rx.rd_ready = 1'b0;
            1:       rx.rd_ready = 1'b1;
            default: rx.rd_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic        hold_vld = 1'b0;
    logic [DW:0] hold_val;
    logic [DW:0] e;

    always @(negedge clk) begin
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld && rx.rd_valid)
                chk("hold_stable", {15'd0, rx.rd_last, rx.rd_data}, {15'd0, hold_val});
            hold_vld = 1'b0;
            if (rx.rd_valid && rx.rd_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got last=%0b data=0x%0h, required no beat",
                             rx.rd_last, rx.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {15'd0, rx.rd_last, rx.rd_data}, {15'd0, e});
                    if (e[DW]) n_done++;
                end
            end else if (rx.rd_valid) begin
                hold_vld = 1'b1;
                hold_val = {rx.rd_last, rx.rd_data};
            end
        end
    end

    // An accepted burst becomes its beat list; a dropped one contributes nothing.
    task automatic send_burst(input logic b, input bit rnd, input logic [DW-1:0] base);
        logic [DW-1:0] d[8];
        int nb;
        bit acc;
        nb = b ? 4 : 8;
        for (int i = 0; i < 8; i++) d[i] = rnd ? DW'($urandom) : base + DW'(i);
        acc = (n_acc - n_done) < SLOTS;
        @(posedge clk); #1;
        rx.listen = 1'b1;
        rx.bc4    = b;
        @(posedge clk); #1;
        rx.listen = 1'b0;
        if (acc) begin
            n_acc++;
            for (int i = 0; i < nb; i++) exp_q.push_back({(i == nb - 1), d[i]});
        end
        #3;
        for (int k = 0; k < nb / 2; k++) begin
            rx.din = d[2*k];
            #2 rx.strobe = 1'b1;
            #3 rx.din = d[2*k+1];
            #2 rx.strobe = 1'b0;
            #3;
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({name, "_idle_valid"}, {31'd0, rx.rd_valid}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rx.listen   = 1'b0;
        rx.bc4      = 1'b0;
        rx.strobe   = 1'b0;
        rx.din      = '0;
        rx.rd_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid",    {31'd0, rx.rd_valid}, 32'd0);
        chk("reset_last",     {31'd0, rx.rd_last},  32'd0);
        chk("reset_overflow", {31'd0, rx.overflow}, 32'd0);
        chk("reset_data",     {16'd0, rx.rd_data},  32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Single BL8 burst with known data.
        ready_mode = 1;
        send_burst(1'b0, 1'b0, 16'h1000);
        wait_drain("bl8_single");

        // BC4 followed by BL8.
        send_burst(1'b1, 1'b0, 16'h3000);
        send_burst(1'b0, 1'b0, 16'h4000);
        wait_drain("bc4_bl8");

        // Stall mid-burst for 5 cycles.
        send_burst(1'b0, 1'b0, 16'h2000);
        cyc = 0;
        while (!rx.rd_valid && cyc < 50) begin @(posedge clk); cyc++; end
        chk("bp_valid_seen", {31'd0, rx.rd_valid}, 32'd1);
        repeat (3) @(posedge clk);
        ready_mode = 0;
        repeat (5) @(posedge clk);
        ready_mode = 1;
        wait_drain("backpressure");

        // Fill all slots with no drain, then one more listen.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 4; k++) send_burst(1'($urandom_range(0, 1)), 1'b1, '0);
        @(negedge clk);
        chk("ovf_before", {31'd0, rx.overflow}, 32'd0);
        send_burst(1'b0, 1'b1, '0);
        @(negedge clk);
        chk("ovf_after", {31'd0, rx.overflow}, 32'd1);
        chk("ovf_pending_beats", 32'(exp_q.size()) >= 32'd16 ? 32'd1 : 32'd0, 32'd1);
        chk("ovf_valid_held", {31'd0, rx.rd_valid}, 32'd1);
        ready_mode = 1;
        wait_drain("overflow");
        chk("ovf_sticky", {31'd0, rx.overflow}, 32'd1);

        // Ten BL8 bursts across the slot wrap with continuous drain.
        for (int k = 0; k < 10; k++) begin
            send_burst(1'b0, 1'b1, '0);
            repeat ($urandom_range(3, 6)) @(posedge clk);
        end
        wait_drain("wrap");

        // Mixed modes with random ready.
        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            send_burst(1'($urandom_range(0, 1)), 1'b1, '0);
            repeat (10) @(posedge clk);
        end
        wait_drain("random_ready");
        ready_mode = 1;

        // Stray strobe pulse without listen must be ignored.
        rx.din = 16'hDEAD;
        #2 rx.strobe = 1'b1;
        #5 rx.strobe = 1'b0;
        wait_drain("stray_strobe");

        // Reset after three edges of a burst.
        @(posedge clk); #1;
        rx.listen = 1'b1;
        rx.bc4    = 1'b0;
        @(posedge clk); #1;
        rx.listen = 1'b0;
        #3 rx.din = 16'hAAA0;
        #2 rx.strobe = 1'b1;
        #3 rx.din = 16'hAAA1;
        #2 rx.strobe = 1'b0;
        #3 rx.din = 16'hAAA2;
        #2 rx.strobe = 1'b1;
        #3 reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid",    {31'd0, rx.rd_valid}, 32'd0);
        chk("rst_mid_overflow", {31'd0, rx.overflow}, 32'd0);
        rx.strobe = 1'b0;
        exp_q.delete();
        n_acc  = 0;
        n_done = 0;
        repeat (2) @(posedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        send_burst(1'b0, 1'b1, '0);
        wait_drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
